dp_ram_pipe: RTL and testbench
==============================

Name: dp_ram_pipe

Overview:
Parametrised simple dual-port RAM: one write port, one independent read port, single clock domain. Successor to the fixed-size dp_ram, adding:
- byte-enable writes
- configurable read latency (1 or 2)
- selectable read-during-write collision mode
- per-word "written since reset" tracking
- out-of-range address detection
Used as the storage primitive under buffers and register files in the memory subsystem.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RD_MODE, 1, same-address collision: 0 = read returns old data, 1 = read returns newly written data (write-first)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset
wr_en  input  1  write request, sampled at rising edge
wr_addr  input  ADDR_W  write address
w_data  input  DATA_W  write data
w_be  input  DATA_W/8  byte enables; bit i gates w_data[8i+7:8i]
rd_en  input  1  read request, sampled at rising edge
rd_addr  input  ADDR_W  read address
r_data  output  DATA_W  read data, registered
r_valid  output  1  r_data/r_init/r_err qualify this cycle
r_init  output  1  addressed word has been written since reset
r_err  output  1  read address was >= DEPTH
wr_err  output  1  one-cycle pulse: previous-edge write had wr_addr >= DEPTH (write dropped)

Behaviour:
- Reset (rst=0, asynchronous):
  - r_data=0, r_valid=0, r_init=0, r_err=0, wr_err=0.
  - Read pipeline stages flushed; all DEPTH init bits cleared.
  - Array contents are not reset.
  - A read in flight when reset asserts is discarded; no r_valid follows after release.
- Write, edge with wr_en=1 and wr_addr<DEPTH:
  - Each byte with w_be[i]=1 is updated; other bytes are unchanged.
  - The word's init bit is set, even when w_be=0.
- Write with wr_addr>=DEPTH: array and init bits untouched; wr_err=1 for exactly the following cycle.
- Read, edge N with rd_en=1:
  - r_valid=1 for exactly one cycle, starting after edge N+RD_LAT-1. RD_LAT=1 means visible right after edge N.
  - Back-to-back reads are fully pipelined: one result per cycle, in issue order.
- Read result contents:
  - Word never written since reset: r_data=0, r_init=0.
  - Otherwise r_init=1 and r_data = stored word.
  - rd_addr>=DEPTH: r_err=1, r_data=0, r_init=0.
- r_valid=0 cycles: r_data, r_init and r_err hold their last values.
- Collision (wr_en=1, rd_en=1, same in-range address, same edge):
  - RD_MODE=0: r_data = pre-write word. r_init = pre-write init bit.
  - RD_MODE=1: r_data = merge, taking enabled bytes from w_data and the rest from the old word (old bytes read as 0 if the word was uninitialised). r_init=1.
- Different addresses on the same edge: fully independent, no interaction.
- RD_LAT=2: a write landing between a read's issue and its output does not alter that read's result.
- wr_addr, rd_addr, w_data and w_be are don't-care when their enable is 0.
- Illegal parameters (RD_LAT not 1/2, DATA_W%8!=0, DEPTH>2**ADDR_W) are rejected at elaboration.

Test Plan:
1. Defaults: reset, then read addr 3 -> next cycle r_valid=1, r_init=0, r_data=0. Then write 0xDEADBEEF to addr 3 with w_be=0xF, read addr 3 -> r_data=0xDEADBEEF, r_init=1.
2. Byte enables: write 0x11223344 to addr 5 (be=0xF), then 0xAABBCCDD with be=0x5, read addr 5 -> r_data=0x11BB33DD.
3. Collision: addr 7 holds 0x00000001; same-edge write 0x12345678 (be=0xF) and read of addr 7 -> RD_MODE=1 returns 0x12345678, RD_MODE=0 returns 0x00000001; a subsequent read returns 0x12345678 in both modes.
4. RD_LAT=2, reads of addrs 0,1,2 issued on consecutive edges (words preloaded 0xA0,0xA1,0xA2) -> r_valid high for 3 consecutive cycles, starting 2 edges after the first issue, data 0xA0,0xA1,0xA2 in order.
5. DEPTH=12, ADDR_W=4: write to addr 13 -> wr_err pulses 1 cycle, no array change. Read addr 13 -> r_err=1, r_data=0. Read addr 11 -> r_err=0.
6. Reset mid-operation: write addr 2, issue read of addr 2 with RD_LAT=2, pull rst low before the result appears -> no r_valid ever appears for that read. After release, read addr 2 -> r_init=0, r_data=0.

Source files
------------

// File: rtl/dp_ram_pipe.sv
// rtl/dp_ram_pipe.sv - simple dual-port RAM with byte enables, 1/2-cycle read latency and init tracking
module dp_ram_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int RD_LAT  = 1,
  parameter int RD_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_valid,
  output logic                  r_init,
  output logic                  r_err,
  output logic                  wr_err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("dp_ram_pipe: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
      $error("dp_ram_pipe: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("dp_ram_pipe: DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  init_q, init_d;
  logic              wr_err_q;
  logic              r_valid_q, r_init_q, r_err_q;
  logic [DATA_W-1:0] r_data_q;

  logic              wr_in, rd_in, wr_ok;
  logic [DATA_W-1:0] wr_old, wr_word_d;
  logic [DATA_W-1:0] rd_word_d;
  logic              rd_init_d, rd_err_d;

  assign wr_in = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_ok = wr_en & wr_in;

  // Bytes not enabled keep the old word; an uninitialised word contributes zeros,
  // so a partial first write never leaves undefined bytes in the array.
  always_comb begin
    wr_old = '0;
    if (wr_in && init_q[wr_addr]) wr_old = mem_q[wr_addr];
    wr_word_d = wr_old;
    for (int i = 0; i < NB; i++) begin
      if (w_be[i]) wr_word_d[8*i +: 8] = w_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word_d = '0;
    rd_init_d = 1'b0;
    rd_err_d  = ~rd_in;
    if (rd_in) begin
      rd_init_d = init_q[rd_addr];
      if (rd_init_d) rd_word_d = mem_q[rd_addr];
      if (RD_MODE == 1 && wr_ok && wr_addr == rd_addr) begin
        rd_init_d = 1'b1;
        rd_word_d = wr_word_d;
      end
    end
  end

  always_comb begin
    init_d = init_q;
    if (wr_ok) init_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= wr_word_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      init_q   <= init_d;
      wr_err_q <= wr_en & ~wr_in;
    end
  end

  logic              s_vld;
  logic [DATA_W-1:0] s_data;
  logic              s_init, s_err;

  // Read result is captured at issue, so a later write cannot alter an in-flight read.
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              p_vld_q, p_init_q, p_err_q;
      logic [DATA_W-1:0] p_data_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          p_vld_q  <= 1'b0;
          p_data_q <= '0;
          p_init_q <= 1'b0;
          p_err_q  <= 1'b0;
        end else begin
          p_vld_q <= rd_en;
          if (rd_en) begin
            p_data_q <= rd_word_d;
            p_init_q <= rd_init_d;
            p_err_q  <= rd_err_d;
          end
        end
      end

      assign s_vld  = p_vld_q;
      assign s_data = p_data_q;
      assign s_init = p_init_q;
      assign s_err  = p_err_q;
    end else begin : g_lat1
      assign s_vld  = rd_en;
      assign s_data = rd_word_d;
      assign s_init = rd_init_d;
      assign s_err  = rd_err_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_init_q  <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      r_valid_q <= s_vld;
      if (s_vld) begin
        r_data_q <= s_data;
        r_init_q <= s_init;
        r_err_q  <= s_err;
      end
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign r_init  = r_init_q;
  assign r_err   = r_err_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_dp_ram_pipe.sv
// tb/tb_dp_ram_pipe.sv - scoreboard bench driving four parameter variants of dp_ram_pipe in lockstep
module tb_dp_ram_pipe;
  localparam int N = 4;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        i;
    logic        e;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0, w_be = '0;
  logic [31:0] w_data = '0;

  logic [31:0] r_data_w [N];
  logic        r_valid_w [N];
  logic        r_init_w [N];
  logic        r_err_w [N];
  logic        wr_err_w [N];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  res_t        exp_q [N][$];
  int          werr_q [N][$];
  logic [31:0] m_mem [N][16];
  bit          m_init [N][16];
  res_t        mon_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Variants: 0 = lat1/write-first/16, 1 = lat1/read-old/16, 2 = lat2/write-first/12, 3 = lat2/read-old/12
  dp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RD_MODE(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data), .w_be(w_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[0]), .r_valid(r_valid_w[0]),
    .r_init(r_init_w[0]), .r_err(r_err_w[0]), .wr_err(wr_err_w[0]));
  dp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RD_MODE(0)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data), .w_be(w_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[1]), .r_valid(r_valid_w[1]),
    .r_init(r_init_w[1]), .r_err(r_err_w[1]), .wr_err(wr_err_w[1]));
  dp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .RD_MODE(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data), .w_be(w_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[2]), .r_valid(r_valid_w[2]),
    .r_init(r_init_w[2]), .r_err(r_err_w[2]), .wr_err(wr_err_w[2]));
  dp_ram_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .RD_MODE(0)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data), .w_be(w_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[3]), .r_valid(r_valid_w[3]),
    .r_init(r_init_w[3]), .r_err(r_err_w[3]), .wr_err(wr_err_w[3]));

  function automatic int lat_of(input int k);
    return (k < 2) ? 1 : 2;
  endfunction

  function automatic int mode_of(input int k);
    return (k % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int depth_of(input int k);
    return (k < 2) ? 16 : 12;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    merge = old;
    for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  // Scoreboard: every r_valid / wr_err pulse is matched against the next expected entry.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (r_valid_w[k] === 1'b1) begin
        n_checks++;
        if (exp_q[k].size() == 0) begin
          $display("FAIL rd_unexpected inst%0d cyc%0d: got r_valid=1 data=%h, required no result",
                   k, cyc, r_data_w[k]);
        end else begin
          mon_r = exp_q[k].pop_front();
          if (cyc !== mon_r.cyc || r_data_w[k] !== mon_r.d || r_init_w[k] !== mon_r.i ||
              r_err_w[k] !== mon_r.e)
            $display("FAIL rd_result inst%0d: got cyc%0d d=%h i=%b e=%b, required cyc%0d d=%h i=%b e=%b",
                     k, cyc, r_data_w[k], r_init_w[k], r_err_w[k],
                     mon_r.cyc, mon_r.d, mon_r.i, mon_r.e);
          else
            n_pass++;
        end
      end
      if (wr_err_w[k] === 1'b1) begin
        n_checks++;
        if (werr_q[k].size() == 0 || werr_q[k][0] != cyc) begin
          $display("FAIL wr_err inst%0d: got pulse at cyc%0d, required %0s", k, cyc,
                   (werr_q[k].size() == 0) ? "none" : "other cycle");
          if (werr_q[k].size() != 0) void'(werr_q[k].pop_front());
        end else begin
          void'(werr_q[k].pop_front());
          n_pass++;
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra);
    res_t r;
    logic [31:0] old;
    wr_en = we; wr_addr = wa; w_data = wd; w_be = be;
    rd_en = re; rd_addr = ra;
    for (int k = 0; k < N; k++) begin
      if (re) begin
        r.cyc = cyc + lat_of(k);
        if (int'(ra) >= depth_of(k)) begin
          r.d = '0; r.i = 1'b0; r.e = 1'b1;
        end else begin
          r.e = 1'b0;
          r.i = m_init[k][ra];
          r.d = m_init[k][ra] ? m_mem[k][ra] : 32'h0;
          if (mode_of(k) == 1 && we && wa == ra) begin
            r.i = 1'b1;
            r.d = merge(r.d, wd, be);
          end
        end
        exp_q[k].push_back(r);
      end
      if (we) begin
        if (int'(wa) >= depth_of(k)) begin
          werr_q[k].push_back(cyc + 1);
        end else begin
          old = m_init[k][wa] ? m_mem[k][wa] : 32'h0;
          m_mem[k][wa]  = merge(old, wd, be);
          m_init[k][wa] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({r_valid_w[k], r_init_w[k], r_err_w[k], wr_err_w[k]} !== 4'b0000)
        $display("FAIL reset_flags inst%0d: got %b, required 0000", k,
                 {r_valid_w[k], r_init_w[k], r_err_w[k], wr_err_w[k]});
      else n_pass++;
      n_checks++;
      if (r_data_w[k] !== 32'h0)
        $display("FAIL reset_data inst%0d: got %h, required 00000000", k, r_data_w[k]);
      else n_pass++;
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_defaults();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    n_checks++;
    if (r_valid_w[0] !== 1'b1 || r_init_w[0] !== 1'b0 || r_data_w[0] !== 32'h0)
      $display("FAIL uninit_read: got v=%b i=%b d=%h, required v=1 i=0 d=0",
               r_valid_w[0], r_init_w[0], r_data_w[0]);
    else n_pass++;
    drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
    n_checks++;
    if (r_data_w[0] !== 32'hDEADBEEF || r_init_w[0] !== 1'b1)
      $display("FAIL full_write_read: got d=%h i=%b, required d=deadbeef i=1", r_data_w[0], r_init_w[0]);
    else n_pass++;
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_defaults inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 32'hAABBCCDD, 4'h5, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5);
    n_checks++;
    if (r_data_w[0] !== 32'h11BB33DD)
      $display("FAIL byte_en_lat1: got %h, required 11bb33dd", r_data_w[0]);
    else n_pass++;
    idle(1);
    n_checks++;
    if (r_data_w[2] !== 32'h11BB33DD)
      $display("FAIL byte_en_lat2: got %h, required 11bb33dd", r_data_w[2]);
    else n_pass++;
    drive(1'b1, 4'd10, 32'h99999999, 4'h0, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd10);
    n_checks++;
    if (r_init_w[0] !== 1'b1 || r_data_w[0] !== 32'h0)
      $display("FAIL zero_be_init: got i=%b d=%h, required i=1 d=0", r_init_w[0], r_data_w[0]);
    else n_pass++;
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_byte_enable inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'd7, 32'h00000001, 4'hF, 1'b0, 4'd0);
    drive(1'b1, 4'd7, 32'h12345678, 4'hF, 1'b1, 4'd7);
    n_checks++;
    if (r_data_w[0] !== 32'h12345678 || r_data_w[1] !== 32'h00000001)
      $display("FAIL collision: got wf=%h ro=%h, required wf=12345678 ro=00000001",
               r_data_w[0], r_data_w[1]);
    else n_pass++;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
    n_checks++;
    if (r_data_w[0] !== 32'h12345678 || r_data_w[1] !== 32'h12345678)
      $display("FAIL post_collision: got %h/%h, required 12345678", r_data_w[0], r_data_w[1]);
    else n_pass++;
    drive(1'b1, 4'd9, 32'hCAFEF00D, 4'h3, 1'b1, 4'd9);
    n_checks++;
    if (r_data_w[0] !== 32'h0000F00D || r_init_w[0] !== 1'b1 || r_init_w[1] !== 1'b0)
      $display("FAIL collision_uninit: got d=%h i=%b old_i=%b, required d=0000f00d i=1 old_i=0",
               r_data_w[0], r_init_w[0], r_init_w[1]);
    else n_pass++;
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_collision inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd0, 32'hA0, 4'hF, 1'b0, 4'd0);
    drive(1'b1, 4'd1, 32'hA1, 4'hF, 1'b0, 4'd0);
    drive(1'b1, 4'd2, 32'hA2, 4'hF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd0);
    n_checks++;
    if (r_valid_w[2] !== 1'b0)
      $display("FAIL lat2_early: got r_valid=%b, required 0", r_valid_w[2]);
    else n_pass++;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd1);
    n_checks++;
    if (r_valid_w[2] !== 1'b1 || r_data_w[2] !== 32'hA0)
      $display("FAIL b2b_0: got v=%b d=%h, required v=1 d=000000a0", r_valid_w[2], r_data_w[2]);
    else n_pass++;
    drive(1'b1, 4'd1, 32'h0BADF00D, 4'hF, 1'b1, 4'd2);
    n_checks++;
    if (r_valid_w[2] !== 1'b1 || r_data_w[2] !== 32'hA1)
      $display("FAIL b2b_1: got v=%b d=%h, required v=1 d=000000a1", r_valid_w[2], r_data_w[2]);
    else n_pass++;
    idle(1);
    n_checks++;
    if (r_valid_w[2] !== 1'b1 || r_data_w[2] !== 32'hA2)
      $display("FAIL b2b_2: got v=%b d=%h, required v=1 d=000000a2", r_valid_w[2], r_data_w[2]);
    else n_pass++;
    idle(1);
    n_checks++;
    if (r_valid_w[2] !== 1'b0 || r_data_w[2] !== 32'hA2)
      $display("FAIL hold: got v=%b d=%h, required v=0 d=000000a2", r_valid_w[2], r_data_w[2]);
    else n_pass++;
    drive(1'b1, 4'd4, 32'h44444444, 4'hF, 1'b1, 4'd6);
    drive(1'b1, 4'd6, 32'h66666666, 4'hC, 1'b1, 4'd4);
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_back_to_back inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0);
    n_checks++;
    if (wr_err_w[2] !== 1'b1 || wr_err_w[0] !== 1'b0)
      $display("FAIL wr_err_pulse: got d12=%b d16=%b, required 1/0", wr_err_w[2], wr_err_w[0]);
    else n_pass++;
    idle(1);
    n_checks++;
    if (wr_err_w[2] !== 1'b0)
      $display("FAIL wr_err_one_cycle: got %b, required 0", wr_err_w[2]);
    else n_pass++;
    drive(1'b1, 4'd12, 32'h12121212, 4'hF, 1'b0, 4'd0);
    drive(1'b1, 4'd11, 32'h0B0B0B0B, 4'hF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd12);
    n_checks++;
    if (r_err_w[2] !== 1'b1 || r_data_w[2] !== 32'h0 || r_init_w[2] !== 1'b0)
      $display("FAIL rd_oor: got e=%b d=%h i=%b, required e=1 d=0 i=0",
               r_err_w[2], r_data_w[2], r_init_w[2]);
    else n_pass++;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd11);
    idle(1);
    n_checks++;
    if (r_err_w[2] !== 1'b0 || r_data_w[2] !== 32'h0B0B0B0B)
      $display("FAIL rd_last_word: got e=%b d=%h, required e=0 d=0b0b0b0b", r_err_w[2], r_data_w[2]);
    else n_pass++;
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_out_of_range inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'd2, 32'h22222222, 4'hF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
    rst = 1'b0;
    rd_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      werr_q[k].delete();
      for (int a = 0; a < 16; a++) m_init[k][a] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (r_valid_w[k] !== 1'b0)
        $display("FAIL reset_flush inst%0d: got r_valid=%b, required 0", k, r_valid_w[k]);
      else n_pass++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
    n_checks++;
    if (r_init_w[0] !== 1'b0 || r_data_w[0] !== 32'h0)
      $display("FAIL post_reset_read: got i=%b d=%h, required i=0 d=0", r_init_w[0], r_data_w[0]);
    else n_pass++;
    idle(3);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_reset_mid inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    idle(4);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (exp_q[k].size() != 0 || werr_q[k].size() != 0)
        $display("FAIL drain_random inst%0d: got %0d/%0d pending, required 0", k,
                 exp_q[k].size(), werr_q[k].size());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
